// File: rtl/trace_capture_pkg.sv
// Shared types for the trace capture buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package trace_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT,
        POST,
        READ
    } state_t;

endpackage

// File: rtl/trace_ram.sv
// DEPTH x WIDTH sample store with one synchronous write port and one asynchronous read port.
// Latency: write lands on the rising edge; read data follows raddr combinationally.
// Backpressure: none; the owner decides when to write and what to read.
module trace_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture.sv
// Circular capture of a probe bus around a masked trigger, streamed out oldest-first.
// Latency: first sample written one edge after arm; READ entered on the edge of the last post-trigger write.
// Backpressure: rd_data/rd_last hold while rd_valid & !rd_ready; one beat per cycle when rd_ready stays high.
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     arm,
    input  logic [$clog2(DEPTH)-1:0] pre_count,
    input  logic [WIDTH-1:0]         trig_mask,
    input  logic [WIDTH-1:0]         trig_value,
    input  logic [WIDTH-1:0]         probe,
    output logic                     armed,
    output logic                     triggered,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_last
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LAST_IDX = (AW + 1)'(DEPTH - 1);

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   pre_q;
    logic [AW-1:0]   post_n;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   trig_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   cnt;
    logic [AW:0]     rd_cnt;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] ram_rdata;
    logic            hit;
    logic            wr_en;
    logic            last_beat;

    // DEPTH-1 is all ones, so the post-trigger count is simply the complement.
    assign post_n    = ~pre_q;
    assign hit       = ((probe ^ value_q) & mask_q) == '0;
    assign wr_en     = (state == PRE) || (state == WAIT) || (state == POST);
    assign last_beat = (rd_cnt == LAST_IDX);

    trace_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (probe),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: pre-fill, trigger wait, post-fill, drain.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (arm) state_nxt = (pre_count == '0) ? WAIT : PRE;
            PRE:  if (cnt == pre_q - PTR_ONE) state_nxt = WAIT;
            WAIT: if (hit) state_nxt = (post_n == '0) ? READ : POST;
            POST: if (cnt == post_n - PTR_ONE) state_nxt = READ;
            READ: if (rd_ready && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pointers, counters and latched trigger setup.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_q    <= '0;
            mask_q   <= '0;
            value_q  <= '0;
            wr_ptr   <= '0;
            trig_ptr <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            rd_cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arm) begin
                        pre_q   <= pre_count;
                        mask_q  <= trig_mask;
                        value_q <= trig_value;
                        wr_ptr  <= '0;
                        cnt     <= '0;
                    end
                end
                PRE: begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    cnt    <= cnt + PTR_ONE;
                end
                WAIT: begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    if (hit) begin
                        trig_ptr <= wr_ptr;
                        cnt      <= '0;
                        rd_cnt   <= '0;
                        // With no post-trigger samples the readout starts right away.
                        rd_ptr   <= wr_ptr - pre_q;
                    end
                end
                POST: begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    cnt    <= cnt + PTR_ONE;
                    rd_ptr <= trig_ptr - pre_q;
                end
                READ: begin
                    if (rd_ready) begin
                        rd_ptr <= rd_ptr + PTR_ONE;
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status and readout outputs, all zero outside their states.
    always_comb begin
        armed     = 1'b0;
        triggered = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        rd_last   = 1'b0;
        unique case (state)
            PRE, WAIT: armed = 1'b1;
            POST:      triggered = 1'b1;
            READ: begin
                triggered = 1'b1;
                rd_valid  = 1'b1;
                rd_data   = ram_rdata;
                rd_last   = last_beat;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trace_capture.sv
module tb_trace_capture;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       arm;
    logic [3:0] pre_count;
    logic [7:0] trig_mask;
    logic [7:0] trig_value;
    logic [7:0] probe;
    logic       armed;
    logic       triggered;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       rd_last;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t exp_q[$];

    logic toggle_mode = 1'b0;
    int   phase = 0;

    trace_capture #(
        .WIDTH (8),
        .DEPTH (16)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .arm        (arm),
        .pre_count  (pre_count),
        .trig_mask  (trig_mask),
        .trig_value (trig_value),
        .probe      (probe),
        .armed      (armed),
        .triggered  (triggered),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: advance the free-running probe and the ready pattern at the falling edge.
    task automatic tick();
        @(negedge clock);
        probe = probe + 8'h01;
        if (toggle_mode) begin
            rd_ready = (phase % 4 == 0) || (phase % 4 == 3);
            phase++;
        end else begin
            rd_ready = 1'b1;
        end
    endtask

    // arm is seen at edge 0; probe reads 0x10 at edge 1.
    task automatic do_arm(input logic [3:0] pc, input logic [7:0] m, input logic [7:0] v);
        @(negedge clock);
        arm        = 1'b1;
        pre_count  = pc;
        trig_mask  = m;
        trig_value = v;
        probe      = 8'h0F;
        tick();
        arm = 1'b0;
    endtask

    task automatic push_window(input logic [7:0] base);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.d = base + 8'(i);
            e.l = (i == 15);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk({name, " beats remaining"}, exp_q.size(), 0);
        chk({name, " idle rd_valid"}, rd_valid, 0);
        chk({name, " idle triggered"}, triggered, 0);
        chk({name, " idle armed"}, armed, 0);
    endtask

    // Monitor: pop and compare on every accepted beat, check hold while stalled.
    initial begin
        logic       held;
        logic [7:0] hd;
        logic       hl;
        exp_t       e;
        held = 1'b0;
        hd   = '0;
        hl   = 1'b0;
        forever begin
            @(negedge clock);
            #2;
            if (!reset_n) begin
                held = 1'b0;
            end else begin
                if (held && rd_valid) begin
                    chk("hold rd_data", rd_data, hd);
                    chk("hold rd_last", rd_last, hl);
                end
                held = 1'b0;
                if (rd_valid && rd_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected beat: got rd_data 0x%0h, no beat expected", rd_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_data", rd_data, e.d);
                        chk("rd_last", rd_last, e.l);
                    end
                end else if (rd_valid) begin
                    held = 1'b1;
                    hd   = rd_data;
                    hl   = rd_last;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        arm        = 1'b0;
        pre_count  = '0;
        trig_mask  = '0;
        trig_value = '0;
        probe      = '0;
        rd_ready   = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("reset armed", armed, 0);
        chk("reset triggered", triggered, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset rd_data", rd_data, 0);
        chk("reset rd_last", rd_last, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic capture: 4 before trigger 0x20.
        push_window(8'h1C);
        do_arm(4'd4, 8'hFF, 8'h20);
        chk("t1 armed", armed, 1);
        chk("t1 triggered early", triggered, 0);
        repeat (16) tick();
        chk("t1 before hit", triggered, 0);
        tick();
        chk("t1 triggered", triggered, 1);
        chk("t1 armed after hit", armed, 0);
        drain("t1");

        // No pre-trigger samples: READ after hit edge + 15.
        push_window(8'h18);
        do_arm(4'd0, 8'hFF, 8'h18);
        chk("t2 armed", armed, 1);
        repeat (23) tick();
        chk("t2 rd_valid early", rd_valid, 0);
        tick();
        chk("t2 rd_valid", rd_valid, 1);
        chk("t2 first rd_data", rd_data, 8'h18);
        drain("t2");

        // No post-trigger samples: READ directly after the hit.
        push_window(8'h21);
        do_arm(4'd15, 8'hFF, 8'h30);
        repeat (32) tick();
        chk("t3 rd_valid early", rd_valid, 0);
        chk("t3 armed", armed, 1);
        tick();
        chk("t3 rd_valid", rd_valid, 1);
        chk("t3 triggered", triggered, 1);
        drain("t3");

        // Zero mask: hit on the first WAIT sample.
        push_window(8'h10);
        do_arm(4'd2, 8'h00, 8'hAA);
        repeat (2) tick();
        chk("t4 in PRE", triggered, 0);
        tick();
        chk("t4 triggered", triggered, 1);
        drain("t4");

        // Readout under a 1-0-0-1 ready pattern.
        push_window(8'h1C);
        phase       = 0;
        toggle_mode = 1'b1;
        do_arm(4'd4, 8'hFF, 8'h20);
        drain("t5");
        toggle_mode = 1'b0;

        // Reset mid-POST discards the capture; a re-arm works normally.
        do_arm(4'd4, 8'hFF, 8'h20);
        repeat (20) tick();
        chk("t6 in POST", triggered, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("t6 rst armed", armed, 0);
        chk("t6 rst triggered", triggered, 0);
        chk("t6 rst rd_valid", rd_valid, 0);
        chk("t6 rst rd_data", rd_data, 0);
        chk("t6 rst rd_last", rd_last, 0);
        tick();
        reset_n = 1'b1;
        push_window(8'h1C);
        do_arm(4'd4, 8'hFF, 8'h20);
        drain("t6 rearm");

        // arm during PRE and a trigger match during PRE are both ignored.
        push_window(8'h1A);
        do_arm(4'd8, 8'h0F, 8'h02);
        tick();
        arm       = 1'b1;
        pre_count = 4'd0;
        tick();
        arm = 1'b0;
        tick();
        chk("t7 PRE match ignored", triggered, 0);
        chk("t7 still armed", armed, 1);
        repeat (15) tick();
        chk("t7 before hit", triggered, 0);
        tick();
        chk("t7 triggered", triggered, 1);
        drain("t7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_capture.md
# trace_capture

On-chip waveform capture buffer that records a probed bus into a circular memory around a programmable trigger, then streams the captured window out over a valid/ready port. It sits directly upstream of the simulation dump/waveform stage. The same internal signals that land in the VCD can then be captured in hardware and read back sample-by-sample, by a host model or a bench monitor.

## Interface
Parameters:
- WIDTH, 8, probe/sample width in bits
- DEPTH, 16, capture window in samples; power of two, ≥ 4

Ports:
- clock  in  1  single capture clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- arm  in  1  start a capture; sampled only in IDLE
- pre_count  in  $clog2(DEPTH)  samples kept before trigger (0..DEPTH-1); latched on accepted arm
- trig_mask  in  WIDTH  bits participating in trigger compare; latched on arm
- trig_value  in  WIDTH  trigger pattern; latched on arm
- probe  in  WIDTH  bus being captured, one sample per cycle
- armed  out  1  high in PRE or WAIT
- triggered  out  1  high in POST or READ
- rd_valid  out  1  readout sample available
- rd_ready  in  1  consumer accepts sample
- rd_data  out  WIDTH  readout sample, oldest first
- rd_last  out  1  marks final (DEPTH-th) sample

## Operation
- FSM states: IDLE, PRE, WAIT, POST, READ. Reset → IDLE; all outputs 0; pointers and counters 0.
- IDLE: arm=1 → latch pre_count/mask/value, clear wr_ptr. Go to PRE, or to WAIT if pre_count=0.
- PRE: write probe at wr_ptr, wr_ptr++. After pre_count writes → WAIT. Trigger compare ignored.
- WAIT: write every cycle, wr_ptr wraps mod DEPTH. Hit when (probe & mask) == (value & mask).
  - On hit, the hit sample is written and trig_ptr = wr_ptr.
  - P = DEPTH-1-pre_count post-trigger samples remain.
  - P=0 → READ, else POST.
- POST: write P more samples → READ. Window = pre_count samples before trigger + trigger sample + P after = DEPTH.
- READ: rd_ptr starts at (trig_ptr - pre_count) mod DEPTH.
  - rd_data = mem[rd_ptr], read combinationally.
  - Advance on rd_valid & rd_ready.
  - rd_last high on the DEPTH-th sample. Its acceptance → IDLE; rd_valid drops the next cycle.
- arm outside IDLE ignored. No writes outside PRE/WAIT/POST.
- mask=0 → hit on first WAIT cycle.
- WAIT never times out; only reset_n leaves it.
- All pointer arithmetic is modulo DEPTH via natural $clog2(DEPTH)-bit wrap.
- Read counter is $clog2(DEPTH)+1 bits.

## Timing
- arm sampled at edge 0 → first PRE write at edge 1 (probe value present before edge 1).
- Trigger hit sampled at edge k → POST writes at edges k+1..k+P. State = READ and rd_valid=1 after edge k+P; for P=0, after edge k.
- rd_data/rd_last stable while rd_valid & !rd_ready. One sample per cycle at full throughput.
- reset_n low at any time, including mid-POST or mid-READ: immediate IDLE, outputs 0, capture discarded. Memory contents need no reset.
- Simultaneous rd_ready with final sample and a new arm: arm ignored that cycle, since the block is not yet IDLE.

## Structure
- trace_capture_pkg: state enum typedef (IDLE/PRE/WAIT/POST/READ); no other shared constants.
- Sub-module trace_ram: DEPTH×WIDTH register array, one synchronous write port, one asynchronous read port.
- FSM, pointers and counters live in trace_capture.

## Test plan
Bench uses WIDTH=8, DEPTH=16; probe = free-running counter, 0x10 on the first sample after arm.
- pre_count=4, mask=0xFF, value=0x20 → triggered after sample 0x20. Readout 0x1C..0x2B (16 beats), rd_last on 0x2B.
- pre_count=0, value=0x18 → first rd_data 0x18, last 0x27; rd_valid high the cycle after trigger edge + 15.
- pre_count=15, value=0x30 → P=0. READ entered the cycle after the hit; readout 0x21..0x30.
- mask=0x00, pre_count=2 → trigger on the first WAIT sample (0x12); readout 0x10..0x1F.
- rd_ready toggled 1-0-0-1 → rd_data/rd_last hold while low. 16 distinct beats total, no duplicates or drops. Return to IDLE after last accept.
- reset_n pulsed low mid-POST → all outputs 0 at once. Re-arm afterwards captures correctly. arm asserted in PRE, and a trigger match during PRE, are both ignored.
